// File: rtl/tick_gen_pkg.sv
// -----------------------------------------------------------------------------
// tick_gen_pkg
// Shared types, constants and helpers for the multi-channel tick generator.
//   tick_mode_t      : periodic or one-shot channel behaviour
//   SIM_DIVISOR      : short reset divisor used when SIMULATE is set
//   default_divisor  : reset-time divisor derived from clock and tick rates
// -----------------------------------------------------------------------------
package tick_gen_pkg;

    typedef enum logic {
        TICK_PERIODIC = 1'b0,
        TICK_ONESHOT  = 1'b1
    } tick_mode_t;

    localparam longint unsigned SIM_DIVISOR = 64'd6;

    // Reset divisor: clk_hz/tick_hz, or the short simulation divisor.
    // A zero tick rate yields 0 so the elaboration check can flag it.
    function automatic longint unsigned default_divisor(
        input longint unsigned clk_hz,
        input longint unsigned tick_hz,
        input bit              simulate
    );
        longint unsigned div_v;
        if (simulate) begin
            div_v = SIM_DIVISOR;
        end else if (tick_hz == 64'd0) begin
            div_v = 64'd0;
        end else begin
            div_v = clk_hz / tick_hz;
        end
        return div_v;
    endfunction

endpackage : tick_gen_pkg

// File: rtl/tick_channel.sv
// -----------------------------------------------------------------------------
// tick_channel
// One programmable tick channel: divisor/mode register, counter, one-shot
// armed flag and registered tick/busy outputs.
// Ports:
//   clk, reset_n    : clock, asynchronous active-low reset
//   enable          : level-sensitive run enable
//   restart         : clear counter and re-arm (no divisor change)
//   load            : load load_divisor/load_mode, clear counter, re-arm
//   load_divisor    : new divisor D (0 = idle)
//   load_mode       : 0 = periodic, 1 = one-shot
//   tick            : registered single-cycle tick
//   busy            : registered "enabled, D != 0 and armed"
// -----------------------------------------------------------------------------
module tick_channel
    import tick_gen_pkg::*;
#(
    parameter int               CNT_W     = 32,
    parameter logic [CNT_W-1:0] RESET_DIV = {{(CNT_W-3){1'b0}}, 3'd6}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             restart,
    input  logic             load,
    input  logic [CNT_W-1:0] load_divisor,
    input  logic             load_mode,
    output logic             tick,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] divisor_r, divisor_s;
    logic [CNT_W-1:0] count_r,   count_s;
    tick_mode_t       mode_r,    mode_s;
    logic             armed_r,   armed_s;
    logic             tick_r,    tick_s;
    logic             busy_r,    busy_s;
    logic             terminal_s;

    // Next-state logic: load beats restart beats idle beats normal counting,
    // so a write or restart on the terminal-count edge suppresses the tick.
    always_comb begin
        divisor_s  = divisor_r;
        mode_s     = mode_r;
        count_s    = count_r;
        armed_s    = armed_r;
        tick_s     = 1'b0;
        terminal_s = (count_r == (divisor_r - CNT_ONE));
        if (load) begin
            divisor_s = load_divisor;
            mode_s    = tick_mode_t'(load_mode);
            count_s   = CNT_ZERO;
            armed_s   = 1'b1;
        end else if (restart) begin
            count_s = CNT_ZERO;
            armed_s = 1'b1;
        end else if (!enable || (divisor_r == CNT_ZERO) || !armed_r) begin
            count_s = CNT_ZERO;
        end else if (terminal_s) begin
            count_s = CNT_ZERO;
            tick_s  = 1'b1;
            if (mode_r == TICK_ONESHOT) begin
                armed_s = 1'b0;
            end else begin
                armed_s = armed_r;
            end
        end else begin
            count_s = count_r + CNT_ONE;
        end
        // busy reflects the state the channel is in after this edge
        busy_s = enable && (divisor_s != CNT_ZERO) && armed_s;
    end

    // Channel state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            divisor_r <= RESET_DIV;
            mode_r    <= TICK_PERIODIC;
            count_r   <= CNT_ZERO;
            armed_r   <= 1'b1;
            tick_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            divisor_r <= divisor_s;
            mode_r    <= mode_s;
            count_r   <= count_s;
            armed_r   <= armed_s;
            tick_r    <= tick_s;
            busy_r    <= busy_s;
        end
    end

    assign tick = tick_r;
    assign busy = busy_r;

endmodule : tick_channel

// File: rtl/multi_tick_gen.sv
// -----------------------------------------------------------------------------
// multi_tick_gen
// NUM_CH independent programmable tick generators used as clock enables.
// Ports:
//   clk, reset_n  : system clock, asynchronous active-low reset
//   ch_enable     : per-channel run enable
//   sync_restart  : pulse, clears all counters and re-arms all one-shots
//   cfg_valid     : config write request
//   cfg_ready     : registered; low for one cycle after every accepted write
//   cfg_ch        : target channel (values >= NUM_CH are accepted, ignored)
//   cfg_divisor   : new divisor (0 = channel idle)
//   cfg_mode      : 0 = periodic, 1 = one-shot
//   tick_out      : registered single-cycle ticks
//   busy          : per-channel enabled-and-counting status
// -----------------------------------------------------------------------------
module multi_tick_gen
    import tick_gen_pkg::*;
#(
    parameter int      NUM_CH            = 4,
    parameter int      CNT_W             = 32,
    parameter longint  CLK_INPUT_FREQ_HZ = 100_000_000,
    parameter longint  DEFAULT_TICK_HZ   = 100_000,
    parameter bit      SIMULATE          = 1'b0,
    localparam int     CH_W              = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic              sync_restart,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_divisor,
    input  logic              cfg_mode,
    output logic [NUM_CH-1:0] tick_out,
    output logic [NUM_CH-1:0] busy
);

    localparam longint unsigned DEF_DIV_L = default_divisor(
        longint'(CLK_INPUT_FREQ_HZ), longint'(DEFAULT_TICK_HZ), SIMULATE);

    localparam logic [CNT_W-1:0] RESET_DIV = DEF_DIV_L[CNT_W-1:0];

    // Elaboration-time sanity checks on parameters
    if ((NUM_CH < 1) || (NUM_CH > 16)) begin : g_bad_num_ch
        $error("multi_tick_gen: NUM_CH must be in 1..16");
    end
    if ((DEF_DIV_L < 64'd1) ||
        ((CNT_W < 64) && (DEF_DIV_L >= (64'd1 << CNT_W)))) begin : g_bad_div
        $error("multi_tick_gen: default divisor must be >= 1 and fit in CNT_W");
    end

    logic              cfg_ready_r;
    logic              accept_s;
    logic [NUM_CH-1:0] load_s;

    assign accept_s = cfg_valid && cfg_ready_r;

    // Handshake: ready drops for exactly one cycle after each accept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_ready_r <= 1'b1;
        end else if (accept_s) begin
            cfg_ready_r <= 1'b0;
        end else begin
            cfg_ready_r <= 1'b1;
        end
    end

    assign cfg_ready = cfg_ready_r;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // An out-of-range cfg_ch matches no channel, so the write is dropped
        assign load_s[i] = accept_s && (cfg_ch == CH_W'(i));

        tick_channel #(
            .CNT_W     (CNT_W),
            .RESET_DIV (RESET_DIV)
        ) u_ch (
            .clk          (clk),
            .reset_n      (reset_n),
            .enable       (ch_enable[i]),
            .restart      (sync_restart),
            .load         (load_s[i]),
            .load_divisor (cfg_divisor),
            .load_mode    (cfg_mode),
            .tick         (tick_out[i]),
            .busy         (busy[i])
        );
    end

endmodule : multi_tick_gen

// File: tb/tb_multi_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_multi_tick_gen
// Directed steps following the test plan, then a randomized phase, all checked
// against a behavioural model that tracks "enabled edges since the last start"
// per channel and fires when that count reaches the divisor.
// -----------------------------------------------------------------------------
module tb_multi_tick_gen;

    localparam int NCH = 4;
    localparam int CW  = 32;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [NCH-1:0] ch_enable = '0;
    logic           sync_restart = 1'b0;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [1:0]     cfg_ch = '0;
    logic [CW-1:0]  cfg_divisor = '0;
    logic           cfg_mode = 1'b0;
    logic [NCH-1:0] tick_out;
    logic [NCH-1:0] busy;

    multi_tick_gen #(
        .NUM_CH            (NCH),
        .CNT_W             (CW),
        .CLK_INPUT_FREQ_HZ (100_000_000),
        .DEFAULT_TICK_HZ   (100_000),
        .SIMULATE          (1'b1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ch_enable    (ch_enable),
        .sync_restart (sync_restart),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ch       (cfg_ch),
        .cfg_divisor  (cfg_divisor),
        .cfg_mode     (cfg_mode),
        .tick_out     (tick_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int unsigned    m_div   [NCH];
    bit             m_one   [NCH];
    bit             m_fired [NCH];
    int unsigned    m_elap  [NCH];
    logic [NCH-1:0] m_tick;
    logic [NCH-1:0] m_busy;
    bit             m_ready;
    bit             m_last_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_div[i]   = 6;
            m_one[i]   = 1'b0;
            m_fired[i] = 1'b0;
            m_elap[i]  = 0;
        end
        m_tick     = '0;
        m_busy     = '0;
        m_ready    = 1'b1;
        m_last_acc = 1'b0;
    endtask

    // One clock edge: update the model from the inputs seen at that edge,
    // then compare all outputs 1 time unit later.
    task automatic step();
        bit acc;
        @(posedge clk);
        acc = cfg_valid && m_ready;
        for (int i = 0; i < NCH; i++) begin
            if (acc && (int'(cfg_ch) == i)) begin
                m_div[i] = cfg_divisor; m_one[i] = cfg_mode;
                m_elap[i] = 0; m_fired[i] = 1'b0; m_tick[i] = 1'b0;
            end else if (sync_restart) begin
                m_elap[i] = 0; m_fired[i] = 1'b0; m_tick[i] = 1'b0;
            end else if (!ch_enable[i] || m_div[i] == 0 || m_fired[i]) begin
                m_elap[i] = 0; m_tick[i] = 1'b0;
            end else begin
                m_elap[i]++;
                if (m_elap[i] == m_div[i]) begin
                    m_tick[i] = 1'b1; m_elap[i] = 0;
                    if (m_one[i]) m_fired[i] = 1'b1;
                end else begin
                    m_tick[i] = 1'b0;
                end
            end
            m_busy[i] = ch_enable[i] && (m_div[i] != 0) && !m_fired[i];
        end
        m_ready    = !acc;
        m_last_acc = acc;
        #1;
        check("model_tick", 32'(tick_out), 32'(m_tick));
        check("model_busy", 32'(busy), 32'(m_busy));
        check("model_ready", 32'(cfg_ready), 32'(m_ready));
    endtask

    // Present a write and hold it until accepted (bounded)
    task automatic cfg_write(input int ch, input int d, input bit mode);
        cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_divisor = CW'(d); cfg_mode = mode;
        for (int n = 0; n < 3; n++) begin
            step();
            if (m_last_acc) break;
        end
        check("cfg_accept", 32'(m_last_acc), 32'd1);
        cfg_valid = 1'b0;
    endtask

    initial begin
        int cnt;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_tick", 32'(tick_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        reset_n = 1'b1;

        // 1: reset divisor 6 on all channels
        ch_enable = 4'hF;
        for (int k = 1; k <= 12; k++) begin
            step();
            check("t1_tick", 32'(tick_out), (k % 6 == 0) ? 32'hF : 32'h0);
            check("t1_busy", 32'(busy), 32'hF);
        end

        // 2: ch1 D=4 periodic, enabled after the write
        ch_enable = 4'b1101;
        cfg_write(1, 4, 1'b0);
        check("t2_ready_low", 32'(cfg_ready), 32'd0);
        ch_enable = 4'hF;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) check("t2_ready_high", 32'(cfg_ready), 32'd1);
            check("t2_tick1", 32'(tick_out[1]), 32'((k % 4) == 0));
        end

        // 3: ch2 D=3 one-shot, then sync_restart re-arms it
        cfg_write(2, 3, 1'b1);
        cnt = 0;
        for (int k = 1; k <= 25; k++) begin
            step();
            check("t3_shot", 32'(tick_out[2]), 32'(k == 3));
            if (tick_out[2]) cnt++;
        end
        check("t3_count", 32'(cnt), 32'd1);
        check("t3_busy_off", 32'(busy[2]), 32'd0);
        sync_restart = 1'b1; step(); sync_restart = 1'b0;
        check("t3_rearm_busy", 32'(busy[2]), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            step();
            check("t3_shot2", 32'(tick_out[2]), 32'(k == 3));
        end

        // 4: ch0 D=5, restart mid-count and on the terminal edge
        cfg_write(0, 5, 1'b0);
        repeat (3) step();
        sync_restart = 1'b1; step(); sync_restart = 1'b0;
        repeat (4) step();
        sync_restart = 1'b1; step(); sync_restart = 1'b0;
        check("t4_tc_restart", 32'(tick_out[0]), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            step();
            check("t4_tick0", 32'(tick_out[0]), 32'(k == 5));
        end

        // 5: ch3 D=0 idles, D=1 ticks every cycle
        cfg_write(3, 0, 1'b0);
        for (int k = 1; k <= 50; k++) begin
            step();
            check("t5_idle_tick", 32'(tick_out[3]), 32'd0);
            check("t5_idle_busy", 32'(busy[3]), 32'd0);
        end
        cfg_write(3, 1, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            step();
            check("t5_d1", 32'(tick_out[3]), 32'd1);
        end

        // Held cfg_valid: accepted, skipped on the ready-low cycle, accepted again
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_divisor = 32'd2; cfg_mode = 1'b0;
        step(); check("hold_acc1", 32'(cfg_ready), 32'd0);
        step(); check("hold_gap", 32'(cfg_ready), 32'd1);
        step(); check("hold_acc2", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b0;
        repeat (3) step();

        // 6: asynchronous reset between edges
        #3 reset_n = 1'b0;
        #1;
        check("t6_async_tick", 32'(tick_out), 32'd0);
        check("t6_async_busy", 32'(busy), 32'd0);
        check("t6_async_ready", 32'(cfg_ready), 32'd1);
        #2 reset_n = 1'b1;
        model_reset();
        for (int k = 1; k <= 12; k++) begin
            step();
            check("t6_default", 32'(tick_out), (k % 6 == 0) ? 32'hF : 32'h0);
        end

        // Randomized phase against the model
        for (int k = 0; k < 400; k++) begin
            ch_enable    = ($urandom % 8 == 0) ? 4'($urandom) : ch_enable | 4'($urandom);
            cfg_valid    = ($urandom % 4 == 0);
            cfg_ch       = 2'($urandom);
            cfg_divisor  = CW'($urandom % 8);
            cfg_mode     = 1'($urandom);
            sync_restart = ($urandom % 16 == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_multi_tick_gen

// File: doc/multi_tick_gen.md
Name: multi_tick_gen

Overview:
- Multi-channel, run-time programmable successor to the single fixed-rate tick divider.
- Generates NUM_CH independent single-cycle tick pulses from the system clock.
- Each channel has a loadable divisor, a periodic or one-shot mode, and an enable.
- Sits between the system clock domain and the slow-rate consumers (debouncers, display refresh, sample strobes); ticks are used as clock enables, never as clocks.

Parameters:
- NUM_CH, 4, number of independent tick channels (1..16).
- CNT_W, 32, divisor/counter width in bits.
- CLK_INPUT_FREQ_HZ, 100_000_000, input clock frequency in Hz.
- DEFAULT_TICK_HZ, 100_000, reset-time tick rate for every channel.
- SIMULATE, 0, when 1 the reset divisor is 6 instead of CLK_INPUT_FREQ_HZ/DEFAULT_TICK_HZ.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- ch_enable  input  NUM_CH  per-channel run enable, level-sensitive.
- sync_restart  input  1  one-cycle pulse: clears all counters and re-arms all one-shots.
- cfg_valid  input  1  config write request.
- cfg_ready  output  1  config write can be accepted this cycle.
- cfg_ch  input  $clog2(NUM_CH) (min 1)  target channel of the config write.
- cfg_divisor  input  CNT_W  new divisor D.
- cfg_mode  input  1  0 = periodic, 1 = one-shot.
- tick_out  output  NUM_CH  registered 1-cycle tick per channel.
- busy  output  NUM_CH  channel enabled and counting (for a one-shot: armed and not yet fired).

Behaviour:
- Reset (async assert, sync release) sets, for every channel:
  - divisor = default (CLK_INPUT_FREQ_HZ/DEFAULT_TICK_HZ, or 6 if SIMULATE);
  - mode = periodic, counter = 0, tick_out = 0, one-shot armed;
  - also busy = 0 and cfg_ready = 1.
- Elaboration check: the default divisor must fit in CNT_W and be >= 1.
- Counting, per channel, with divisor D >= 1 and ch_enable high:
  - the counter increments each edge;
  - on an edge where counter == D-1, the counter goes to 0 and tick_out is 1 for the following cycle; otherwise tick_out is 0.
  - The first tick is asserted after the D-th enabled edge, then every D cycles. D = 1 gives tick_out continuously high.
- D = 0: the channel is idle; counter held at 0, no ticks, busy = 0.
- ch_enable low: counter cleared to 0, tick_out 0 next cycle, busy 0. Re-enable restarts the full D-cycle interval.
- One-shot mode: after its single tick the channel disarms and holds counter 0 with busy 0 until re-armed. Re-arm is by a config write to that channel or by sync_restart.
- Config handshake:
  - A write is accepted on an edge where cfg_valid && cfg_ready.
  - On that edge the target channel loads divisor and mode, clears its counter, re-arms, and forces tick_out low.
  - cfg_ready is registered and drops for exactly one cycle after each accept, so at most one write every 2 cycles.
  - cfg_valid held during the low cycle is accepted on the following edge.
  - A cfg_ch value >= NUM_CH is accepted and ignored.
- sync_restart: on that edge all counters go to 0, all one-shots re-arm, and all tick_out are 0 next cycle. Enable and divisors are unaffected.
- Simultaneous sync_restart and config accept: both apply; the written channel takes its new divisor and every channel starts from 0.
- Simultaneous terminal count and config write or sync_restart on the same channel: the write/restart wins and no tick is issued.
- Counter arithmetic is unsigned CNT_W. The counter never exceeds D-1 because a divisor change always clears it.

Decomposition:
- Package tick_gen_pkg holds:
  - typedef enum logic {TICK_PERIODIC, TICK_ONESHOT} tick_mode_t;
  - function default_divisor(clk_hz, tick_hz, simulate);
  - localparam SIM_DIVISOR = 6.
- Sub-module tick_channel: one counter, divisor/mode register, armed flag and tick register. It has load, restart and enable inputs and tick/busy outputs, and is instantiated NUM_CH times in a generate loop.
- The top level holds the config decode, the cfg_ready register and the sync_restart fan-out.

Test Plan:
1. Reset with SIMULATE=1, enable all channels -> each tick_out pulses on every 6th cycle, first pulse 6 cycles after enable; busy = all 1s.
2. Write ch1 D=4 periodic, enable ch1 -> ticks on enabled edges 4, 8, 12; cfg_ready low the cycle after accept, high again the next.
3. Write ch2 D=3 one-shot -> exactly one tick, 3 cycles later, then busy[2] = 0 for 20 cycles; sync_restart -> a second single tick 3 cycles later.
4. ch0 D=5, pulse sync_restart at counter 3, then again on the terminal-count edge -> no tick that cycle; next tick 5 cycles after the last restart.
5. Write ch3 D=0 -> tick_out[3] and busy[3] stay 0 for 50 cycles; write D=1 -> tick_out[3] high every cycle.
6. Assert reset_n low mid-count, asynchronously between edges -> all tick_out/busy clear immediately; after release, divisors are back to 6 and periodic.
